bpsk_pulse_scheduler: RTL

BPSK_PULSE_SCHEDULER -- requirements
Module: bpsk_pulse_scheduler

---
 rtl/bpsk_pkg.sv | 35 +++
 rtl/bpsk_seg_counter.sv | 26 ++
 rtl/bpsk_pulse_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bpsk_pkg.sv
// Shared constants, FSM state codes and configuration record for the BPSK pulse scheduler.
package bpsk_pkg;

  localparam int CODE_W  = 16;
  localparam int LEN_W   = 16;
  localparam int PRI_W   = 24;
  localparam int GUARD_W = 8;

  localparam logic [13:0] DAC_ZERO = 14'h1FFF;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_GUARD_PRE  = 3'd1;
  localparam logic [2:0] ST_TX         = 3'd2;
  localparam logic [2:0] ST_GUARD_POST = 3'd3;
  localparam logic [2:0] ST_LISTEN     = 3'd4;

  typedef struct packed {
    logic [GUARD_W-1:0] guard;
    logic [LEN_W-1:0]   tx;
    logic [PRI_W-1:0]   pri;
    logic [LEN_W-1:0]   n;
    logic [CODE_W-1:0]  code_a;
  } cfg_t;

  // A PRI must hold both guards, the TX window and at least one listen cycle.
  function automatic logic cfg_valid(input logic [GUARD_W-1:0] g,
                                     input logic [LEN_W-1:0]   tx,
                                     input logic [PRI_W-1:0]   pri,
                                     input logic [LEN_W-1:0]   n);
    logic [PRI_W:0] need;
    need = {9'd0, tx} + {16'd0, g, 1'b0} + 25'd1;
    return (tx != '0) && (n != '0) && ({1'b0, pri} >= need);
  endfunction

endpackage

// File: rtl/bpsk_seg_counter.sv
// Loadable down-counter; tc is high while the count sits at zero (last cycle of a segment).
module bpsk_seg_counter #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/bpsk_pulse_scheduler.sv
// Radar burst scheduler: guard / TX / guard / listen per PRI, n_pulses per burst.
// Define BPSK_ALT_CODE_EN to alternate code_a / code_b on even / odd pulses.
module bpsk_pulse_scheduler
  import bpsk_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [CODE_W-1:0]  code_a,
  input  logic [CODE_W-1:0]  code_b,
  input  logic [GUARD_W-1:0] guard_len,
  input  logic [LEN_W-1:0]   tx_len,
  input  logic [PRI_W-1:0]   pri_len,
  input  logic [LEN_W-1:0]   n_pulses,
  output logic               sinc,
  output logic [CODE_W-1:0]  cod,
  output logic               tr_sw,
  output logic               rx_gate,
  output logic [LEN_W-1:0]   pulse_idx,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [2:0]         dbg_state
);

  logic [2:0]        state_q, state_nxt;
  cfg_t              cfg_q;
  logic              accept, reject;
  logic              seg_load, seg_tc;
  logic [PRI_W-1:0]  seg_val;
  logic [PRI_W-1:0]  listen_len;
  logic [LEN_W-1:0]  pidx_nxt;
  logic [CODE_W-1:0] cod_nxt;
  logic              done_nxt;

`ifdef BPSK_ALT_CODE_EN
  logic [CODE_W-1:0] code_b_q;
`else
  logic unused_code_b;
  assign unused_code_b = ^code_b;
`endif

  assign listen_len = cfg_q.pri - {8'd0, cfg_q.tx} - {15'd0, cfg_q.guard, 1'b0};
  assign dbg_state  = state_q;

  bpsk_seg_counter #(.W(PRI_W)) u_seg (
    .clk      (clk),
    .rst      (rst),
    .load     (seg_load),
    .load_val (seg_val),
    .tc       (seg_tc)
  );

  always_comb begin
    state_nxt = state_q;
    seg_load  = 1'b0;
    seg_val   = '0;
    pidx_nxt  = pulse_idx;
    cod_nxt   = cod;
    done_nxt  = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // abort outranks a coincident start; start uses live inputs since they latch now
        if (start && !abort) begin
          if (cfg_valid(guard_len, tx_len, pri_len, n_pulses)) begin
            accept   = 1'b1;
            pidx_nxt = '0;
            cod_nxt  = code_a;
            seg_load = 1'b1;
            if (guard_len != '0) begin
              state_nxt = ST_GUARD_PRE;
              seg_val   = {16'd0, guard_len} - 24'd1;
            end else begin
              state_nxt = ST_TX;
              seg_val   = {8'd0, tx_len} - 24'd1;
            end
          end else begin
            reject   = 1'b1;
            done_nxt = 1'b1;
          end
        end
      end
      ST_GUARD_PRE: begin
        if (seg_tc) begin
          state_nxt = ST_TX;
          seg_load  = 1'b1;
          seg_val   = {8'd0, cfg_q.tx} - 24'd1;
        end
      end
      ST_TX: begin
        if (seg_tc) begin
          seg_load = 1'b1;
          if (cfg_q.guard != '0) begin
            state_nxt = ST_GUARD_POST;
            seg_val   = {16'd0, cfg_q.guard} - 24'd1;
          end else begin
            state_nxt = ST_LISTEN;
            seg_val   = listen_len - 24'd1;
          end
        end
      end
      ST_GUARD_POST: begin
        if (seg_tc) begin
          state_nxt = ST_LISTEN;
          seg_load  = 1'b1;
          seg_val   = listen_len - 24'd1;
        end
      end
      ST_LISTEN: begin
        if (seg_tc) begin
          if (pulse_idx == cfg_q.n - 1'b1) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            pidx_nxt = pulse_idx + 1'b1;
`ifdef BPSK_ALT_CODE_EN
            cod_nxt  = pidx_nxt[0] ? code_b_q : cfg_q.code_a;
`else
            cod_nxt  = cfg_q.code_a;
`endif
            seg_load = 1'b1;
            if (cfg_q.guard != '0) begin
              state_nxt = ST_GUARD_PRE;
              seg_val   = {16'd0, cfg_q.guard} - 24'd1;
            end else begin
              state_nxt = ST_TX;
              seg_val   = {8'd0, cfg_q.tx} - 24'd1;
            end
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && abort) begin
      state_nxt = ST_IDLE;
      done_nxt  = 1'b1;
      seg_load  = 1'b0;
      pidx_nxt  = pulse_idx;
      cod_nxt   = cod;
    end
  end

  // Outputs are flops driven from the next state, so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cfg_q     <= '0;
      sinc      <= 1'b0;
      tr_sw     <= 1'b0;
      rx_gate   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      cod       <= '0;
      pulse_idx <= '0;
    end else begin
      state_q <= state_nxt;
      if (accept) begin
        cfg_q <= '{guard: guard_len, tx: tx_len, pri: pri_len, n: n_pulses, code_a: code_a};
      end
      sinc      <= (state_nxt == ST_TX);
      tr_sw     <= (state_nxt == ST_GUARD_PRE) || (state_nxt == ST_TX) ||
                   (state_nxt == ST_GUARD_POST);
      rx_gate   <= (state_nxt == ST_LISTEN);
      busy      <= (state_nxt != ST_IDLE);
      done      <= done_nxt;
      cod       <= cod_nxt;
      pulse_idx <= pidx_nxt;
      if (reject) begin
        cfg_err <= 1'b1;
      end else if (accept) begin
        cfg_err <= 1'b0;
      end
    end
  end

`ifdef BPSK_ALT_CODE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_b_q <= '0;
    end else if (accept) begin
      code_b_q <= code_b;
    end
  end
`endif

endmodule
